// File: rtl/fsm_state_logger_if.sv
// ============================================================================
// Module   : fsm_state_logger_if
// Brief    : Valid/ready record stream from the state logger to its consumer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fsm_state_logger_if #(
  parameter int TS_W = 12
);
  logic            out_valid;
  logic            out_ready;
  logic [TS_W+3:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/fsm_state_logger.sv
// ============================================================================
// Module   : fsm_state_logger
// Brief    : Timestamps state changes of a 2-bit FSM into a FIFO, flags illegal
//            transitions and counts records lost to overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fsm_state_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 12
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     a,
  input  wire logic                     b,
  input  wire logic                     clr,
  fsm_state_logger_if.master            bus,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          illegal,
  output logic [3:0]                    illegal_code,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_REC_W = TS_W + 4;

  logic [1:0]         r_prev;
  logic [TS_W-1:0]    r_ts;
  logic [c_REC_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_illegal;
  logic [3:0]         r_illegal_code;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;

  logic [1:0]         w_cur;
  logic               w_event;
  logic               w_legal;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  assign w_cur   = {b, a};
  assign w_event = (w_cur != r_prev);
  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;

  always_comb begin
    w_legal = 1'b0;
    case ({r_prev, w_cur})
      4'b0001, 4'b0100, 4'b0111,
      4'b1100, 4'b1011, 4'b1000: w_legal = 1'b1;
      default:                   w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 2'b00;
      r_ts   <= '0;
    end else begin
      r_prev <= w_cur;
      r_ts   <= r_ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_ts, r_prev, w_cur};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // clr is applied first so that an event in the same cycle takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal      <= 1'b0;
      r_illegal_code <= 4'b0000;
      r_overflow     <= 1'b0;
      r_drop_cnt     <= 8'd0;
    end else begin
      if (clr) begin
        r_illegal      <= 1'b0;
        r_illegal_code <= 4'b0000;
        r_overflow     <= 1'b0;
        r_drop_cnt     <= 8'd0;
      end
      if (w_event && !w_legal) begin
        r_illegal <= 1'b1;
        if (!r_illegal || clr) begin
          r_illegal_code <= {r_prev, w_cur};
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clr) begin
          r_drop_cnt <= 8'd1;
        end else if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign count         = r_count;
  assign illegal       = r_illegal;
  assign illegal_code  = r_illegal_code;
  assign overflow      = r_overflow;
  assign drop_cnt      = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fsm_state_logger.sv
// ============================================================================
// Module   : tb_fsm_state_logger
// Brief    : Scoreboard bench for fsm_state_logger (DEPTH=8, TS_W=12).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fsm_state_logger;

  localparam int c_DEPTH = 8;
  localparam int c_TS_W  = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a   = 1'b0;
  logic       b   = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] count;
  logic       illegal;
  logic [3:0] illegal_code;
  logic       overflow;
  logic [7:0] drop_cnt;

  fsm_state_logger_if #(.TS_W(c_TS_W)) intf ();

  fsm_state_logger #(.DEPTH(c_DEPTH), .TS_W(c_TS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .clr          (clr),
    .bus          (intf),
    .count        (count),
    .illegal      (illegal),
    .illegal_code (illegal_code),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [1:0]  tb_prev = 2'b00;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rec(input int t, input logic [1:0] f, input logic [1:0] to);
    logic [31:0] tv;
    tv = t;
    return {tv[11:0], f, to};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive a state code for one cycle; queue the expected record if it should be kept.
  task automatic step(input logic [1:0] s, input bit keep);
    {b, a} = s;
    if (s != tb_prev && keep) exp_q.push_back(rec(cyc, tb_prev, s));
    tb_prev = s;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((count != 0 || exp_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted head record is compared with the scoreboard front.
  always @(negedge clk) begin
    if (!rst && intf.out_valid && intf.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got 0x%0h expected none", intf.out_data);
      end else begin
        chk("record", 32'(intf.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    intf.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(intf.out_valid), 32'd0);
    chk("rst_data", 32'(intf.out_data), 32'd0);
    chk("rst_flags", {illegal, illegal_code, overflow, drop_cnt}, 32'd0);

    // Legal path: 00,01,11,00 on cycles 0,3,4,7
    intf.out_ready = 1'b1;
    hold(3);
    step(2'b01, 1'b1);
    chk("latency_valid", 32'(intf.out_valid), 32'd1);
    chk("latency_data", 32'(intf.out_data), 32'h0031);
    step(2'b11, 1'b1);
    hold(2);
    step(2'b00, 1'b1);
    hold(2);
    chk("legal_no_illegal", 32'(illegal), 32'd0);
    drain();

    // Illegal detection
    step(2'b10, 1'b1);
    chk("illegal_set", 32'(illegal), 32'd1);
    chk("illegal_code", 32'(illegal_code), 32'h2);
    hold(2);
    step(2'b11, 1'b1);
    chk("illegal_code_kept", 32'(illegal_code), 32'h2);
    step(2'b00, 1'b1);
    drain();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_illegal", 32'(illegal), 32'd0);
    chk("clr_code", 32'(illegal_code), 32'd0);

    // clr coinciding with an illegal event: the event wins
    step(2'b10, 1'b1);
    clr = 1'b1;
    step(2'b01, 1'b1);
    clr = 1'b0;
    chk("clr_vs_event_illegal", 32'(illegal), 32'd1);
    chk("clr_vs_event_code", 32'(illegal_code), 32'h9);
    step(2'b00, 1'b1);
    drain();
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Overflow: 10 changes with no consumer
    intf.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 2'b01 : 2'b00, i < 8);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    chk("ovf_valid", 32'(intf.out_valid), 32'd1);

    // Full with simultaneous pop and push
    intf.out_ready = 1'b1;
    step(2'b01, 1'b1);
    intf.out_ready = 1'b0;
    chk("full_popush_count", 32'(count), 32'd8);
    chk("full_popush_drops", 32'(drop_cnt), 32'd2);
    intf.out_ready = 1'b1;
    drain();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_drops", 32'(drop_cnt), 32'd0);

    // Mid-run reset with 3 records queued and illegal set
    intf.out_ready = 1'b0;
    step(2'b10, 1'b1);
    step(2'b11, 1'b1);
    step(2'b01, 1'b1);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_code", 32'(illegal_code), 32'h6);
    {b, a} = 2'b11;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    {b, a} = 2'b00;
    cyc = 0;
    tb_prev = 2'b00;
    exp_q.delete();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(intf.out_valid), 32'd0);
    chk("mid_rst_data", 32'(intf.out_data), 32'd0);
    chk("mid_rst_flags", {illegal, illegal_code, overflow, drop_cnt}, 32'd0);
    tick();
    chk("mid_rst_no_event", 32'(count), 32'd0);
    intf.out_ready = 1'b1;
    hold(4);
    step(2'b01, 1'b1);
    chk("post_rst_ts", 32'(intf.out_data), 32'h0051);
    drain();

    // Timestamp wrap: change at cycle 4097 carries ts 1
    while (cyc < 4097) tick();
    step(2'b00, 1'b1);
    chk("wrap_ts", 32'(intf.out_data[15:4]), 32'd1);
    drain();

    hold(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
